// File: rtl/fixed_div_pkg.sv
// fixed_div_pkg: shared types and constants
// for the 8.8 signed fixed-point divider.
package fixed_div_pkg;

  localparam int DW   = 16;
  localparam int VW   = 8;
  localparam int ITER = 17;

  localparam logic [DW-1:0] SAT_POS = 16'h7FFF;
  localparam logic [DW-1:0] SAT_NEG = 16'h8000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/fixed_div_unit_div_step.sv
// div_step: one combinational restoring
// division iteration (shift in a bit, trial subtract).
module div_step
  import fixed_div_pkg::*;
(
  input  logic [VW:0]   r_in,
  input  logic          bit_in,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   r_out,
  output logic          q_bit
);

  logic [VW:0] trial;
  logic [VW:0] dvs_ext;
  logic        ge;

  // r_in < divisor, so a set top bit means trial is already >= divisor
  always_comb begin
    trial   = {r_in[VW-1:0], bit_in};
    dvs_ext = {1'b0, divisor};
    ge      = r_in[VW] | (trial >= dvs_ext);
    q_bit   = ge;
    r_out   = ge ? (trial - dvs_ext) : trial;
  end

endmodule

// File: rtl/fixed_div_unit.sv
// fixed_div_unit: multi-cycle signed 8.8 / unsigned
// divider, floor rounding, Start/Ack handshake.
module fixed_div_unit
  import fixed_div_pkg::*;
(
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [DW-1:0] Dividend,
  input  logic [VW-1:0] Divisor,
  output logic [DW-1:0] Quotient,
  output logic          DivZero,
  output logic          Busy,
  output logic          Ack
);

  state_t        state_q;
  state_t        state_d;
  logic          sign_q;
  logic [DW:0]   mag_q;
  logic [DW:0]   q_q;
  logic [VW:0]   r_q;
  logic [VW-1:0] dvs_q;
  logic [4:0]    cnt_q;

  logic          accept;
  logic          last_it;
  logic [DW:0]   div_ext;
  logic [DW:0]   mag_in;
  logic [VW:0]   r_nx;
  logic          q_bit;
  logic [DW:0]   q_adj;
  logic [DW:0]   q_neg;
  logic [DW-1:0] fix_val;

  assign accept  = (state_q == IDLE) && Start;
  assign last_it = (cnt_q == 5'(ITER - 1));
  assign Ack     = (state_q == DONE);
  assign Busy    = (state_q != IDLE);

  div_step u_step (
    .r_in    (r_q),
    .bit_in  (mag_q[DW]),
    .divisor (dvs_q),
    .r_out   (r_nx),
    .q_bit   (q_bit)
  );

  // 17-bit magnitude and floor-corrected signed result
  always_comb begin
    div_ext = {Dividend[DW-1], Dividend};
    mag_in  = Dividend[DW-1] ? (~div_ext + 1'b1) : div_ext;
    q_adj   = q_q + {{DW{1'b0}}, (r_q != '0)};
    q_neg   = ~q_adj + 1'b1;
    fix_val = sign_q ? q_neg[DW-1:0] : q_q[DW-1:0];
  end

  // state register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state decode; zero divisor bypasses RUN
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (Start)
              state_d = (Divisor == '0) ? DONE : RUN;
      RUN:  if (last_it) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // capture, shift/iterate, then sign fix-up
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sign_q   <= 1'b0;
      mag_q    <= '0;
      q_q      <= '0;
      r_q      <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      Quotient <= '0;
      DivZero  <= 1'b0;
    end else if (accept) begin
      sign_q <= Dividend[DW-1];
      mag_q  <= mag_in;
      dvs_q  <= Divisor;
      r_q    <= '0;
      q_q    <= '0;
      cnt_q  <= '0;
      if (Divisor == '0) begin
        Quotient <= Dividend[DW-1] ? SAT_NEG : SAT_POS;
        DivZero  <= 1'b1;
      end
    end else if (state_q == RUN) begin
      r_q   <= r_nx;
      q_q   <= {q_q[DW-1:0], q_bit};
      mag_q <= {mag_q[DW-1:0], 1'b0};
      cnt_q <= cnt_q + 5'd1;
    end else if (state_q == FIX) begin
      Quotient <= fix_val;
      DivZero  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fixed_div_unit.sv
// tb_fixed_div_unit: directed self-checking
// bench for the fixed-point divider.
module tb_fixed_div_unit;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [15:0] Dividend;
  logic [7:0]  Divisor;
  logic [15:0] Quotient;
  logic        DivZero;
  logic        Busy;
  logic        Ack;

  int checks;
  int errors;

  fixed_div_unit dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Dividend (Dividend),
    .Divisor  (Divisor),
    .Quotient (Quotient),
    .DivZero  (DivZero),
    .Busy     (Busy),
    .Ack      (Ack)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // present operands with Start for one edge (E0)
  task automatic launch(input logic [15:0] a,
                        input logic [7:0] b);
    Dividend = a;
    Divisor  = b;
    Start    = 1'b1;
    @(posedge Clk);
    #1;
    Start    = 1'b0;
    Dividend = 16'hDEAD;
    Divisor  = 8'hA5;
  endtask

  // edges after E0 until Ack seen; -1 on timeout
  task automatic wait_ack(output int lat);
    lat = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge Clk);
      #1;
      if (Ack) begin
        lat = e;
        return;
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    Start = 1'b0;
    Dividend = '0;
    Divisor = '0;
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if (Quotient !== 16'h0000) begin
      errors++;
      $display("FAIL rst_q got %h want 0000", Quotient);
    end
    checks++;
    if (DivZero !== 1'b0 || Busy !== 1'b0 || Ack !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags got dz=%b busy=%b ack=%b want 0 0 0",
               DivZero, Busy, Ack);
    end
    Reset = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_basic();
    int lat;
    launch(16'h0600, 8'd3);
    checks++;
    if (Busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy got %b want 1", Busy);
    end
    wait_ack(lat);
    checks++;
    if (lat !== 18) begin
      errors++;
      $display("FAIL basic_lat got %0d want 18", lat);
    end
    checks++;
    if (Quotient !== 16'h0200 || DivZero !== 1'b0) begin
      errors++;
      $display("FAIL basic_q got %h dz=%b want 0200 dz=0",
               Quotient, DivZero);
    end
    @(posedge Clk);
    #1;
    checks++;
    if (Busy !== 1'b0 || Ack !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle got busy=%b ack=%b want 0 0",
               Busy, Ack);
    end
  endtask

  // back-to-back issue: each Start in first IDLE cycle after Ack
  task automatic test_rounding();
    logic [15:0] a   [3] = '{16'h3900, 16'hFF00, 16'hFFFF};
    logic [7:0]  b   [3] = '{8'd3, 8'd3, 8'd2};
    logic [15:0] exp [3] = '{16'h1300, 16'hFFAA, 16'hFFFF};
    int lat;
    for (int i = 0; i < 3; i++) begin
      launch(a[i], b[i]);
      wait_ack(lat);
      checks++;
      if (lat !== 18 || Quotient !== exp[i]) begin
        errors++;
        $display("FAIL round%0d got q=%h lat=%0d want q=%h lat=18",
                 i, Quotient, lat, exp[i]);
      end
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic test_extremes();
    logic [15:0] a   [3] = '{16'h8000, 16'h7FFF, 16'h7FFF};
    logic [7:0]  b   [3] = '{8'd1, 8'd1, 8'd255};
    logic [15:0] exp [3] = '{16'h8000, 16'h7FFF, 16'h0080};
    int lat;
    for (int i = 0; i < 3; i++) begin
      launch(a[i], b[i]);
      wait_ack(lat);
      checks++;
      if (Quotient !== exp[i] || DivZero !== 1'b0) begin
        errors++;
        $display("FAIL ext%0d got q=%h dz=%b want q=%h dz=0",
                 i, Quotient, DivZero, exp[i]);
      end
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic test_div_zero();
    logic [15:0] a   [2] = '{16'h1234, 16'h8001};
    logic [15:0] exp [2] = '{16'h7FFF, 16'h8000};
    int lat;
    for (int i = 0; i < 2; i++) begin
      launch(a[i], 8'd0);
      lat = Ack ? 1 : -1;
      if (lat < 0) wait_ack(lat);
      checks++;
      if (lat !== 1) begin
        errors++;
        $display("FAIL dz%0d_lat got %0d want 1", i, lat);
      end
      checks++;
      if (Quotient !== exp[i] || DivZero !== 1'b1) begin
        errors++;
        $display("FAIL dz%0d_q got q=%h dz=%b want q=%h dz=1",
                 i, Quotient, DivZero, exp[i]);
      end
      @(posedge Clk);
      #1;
      checks++;
      if (Busy !== 1'b0) begin
        errors++;
        $display("FAIL dz%0d_idle got busy=%b want 0", i, Busy);
      end
    end
  endtask

  task automatic test_ignored_start();
    int lat;
    launch(16'h0600, 8'd3);
    lat = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge Clk);
      #1;
      if (Ack) begin
        lat = e;
        break;
      end
      Start    = (e == 4) || (e == 11);
      Dividend = (e == 4) ? 16'h7FFF : 16'h8000;
      Divisor  = (e == 4) ? 8'd1 : 8'd0;
    end
    Start = 1'b0;
    checks++;
    if (lat !== 18 || Quotient !== 16'h0200 || DivZero !== 1'b0) begin
      errors++;
      $display("FAIL ign_run got q=%h dz=%b lat=%0d want 0200 0 18",
               Quotient, DivZero, lat);
    end
    Dividend = 16'h1234;
    Divisor  = 8'd0;
    Start    = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    @(posedge Clk);
    #1;
    checks++;
    if (Busy !== 1'b0 || Ack !== 1'b0 || Quotient !== 16'h0200) begin
      errors++;
      $display("FAIL ign_done got busy=%b ack=%b q=%h want 0 0 0200",
               Busy, Ack, Quotient);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    launch(16'h3900, 8'd3);
    repeat (9) @(posedge Clk);
    #1;
    Reset = 1'b0;
    #1;
    checks++;
    if (Quotient !== 16'h0000 || DivZero !== 1'b0 ||
        Busy !== 1'b0 || Ack !== 1'b0) begin
      errors++;
      $display("FAIL midrst got q=%h dz=%b busy=%b ack=%b want 0 0 0 0",
               Quotient, DivZero, Busy, Ack);
    end
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b1;
    lat = 0;
    for (int e = 0; e < 20; e++) begin
      @(posedge Clk);
      #1;
      if (Ack || Busy) lat++;
    end
    checks++;
    if (lat !== 0) begin
      errors++;
      $display("FAIL midrst_quiet got %0d busy cycles want 0", lat);
    end
    launch(16'h0600, 8'd3);
    wait_ack(lat);
    checks++;
    if (lat !== 18 || Quotient !== 16'h0200) begin
      errors++;
      $display("FAIL midrst_fresh got q=%h lat=%0d want 0200 18",
               Quotient, lat);
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_rounding();
    test_extremes();
    test_div_zero();
    test_ignored_start();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
